// File: rtl/minesweeper_game_ctrl.sv
// minesweeper_game_ctrl: game sequencer for an 8x8 minesweeper board.
// Lays out mines at LFSR-chosen, non-repeating positions, waits for the
// board's adjacency counts to settle, then runs cursor/reveal/flag play
// with win/lose detection. The authoritative mine map lives here.
module minesweeper_game_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] DEFAULT_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mine_count,
  input  logic [15:0] seed,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_reveal,
  input  logic        btn_flag,
  input  logic [6:0]  cell_rdata,
  output logic        board_reset,
  output logic [3:0]  total_mines,
  output logic        place_mine,
  output logic [2:0]  row,
  output logic [2:0]  column,
  output logic        cell_we,
  output logic [6:0]  cell_wdata,
  output logic [2:0]  game_state,
  output logic [6:0]  revealed_count,
  output logic [6:0]  flags_used
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_PLACE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_PLAY   = 3'd4;
  localparam logic [2:0] S_WIN    = 3'd5;
  localparam logic [2:0] S_LOSE   = 3'd6;

  localparam logic [2:0] C_HIDDEN   = 3'd0;
  localparam logic [2:0] C_REVEALED = 3'd1;
  localparam logic [2:0] C_FLAG     = 3'd2;
  localparam logic [2:0] C_BOMB     = 3'd3;

  logic [2:0]  state;
  logic [15:0] lfsr;
  logic [63:0] mine_map;
  logic [3:0]  placed;
  logic [3:0]  total_q;
  logic [7:0]  settle_cnt;
  logic [2:0]  cur_r;
  logic [2:0]  cur_c;
  logic [6:0]  revealed_q;
  logic [6:0]  flags_q;
  logic        cell_we_q;
  logic [6:0]  cell_wdata_q;

  logic [5:0]  cand;
  logic        lfsr_fb;
  logic [3:0]  placed_next;
  logic        cur_mine;
  logic [2:0]  rd_cnt;
  logic [2:0]  rd_st;
  logic [6:0]  win_target;
  logic        sel_unused;

  // Placement candidate, board-facing strobes and coordinate mux
  always_comb begin
    cand        = lfsr[5:0];
    lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    place_mine  = (state == S_PLACE) && !mine_map[cand] && (placed != total_q);
    placed_next = placed + {3'b000, place_mine};
    board_reset = (state == S_CLEAR);
    row         = (state == S_PLACE) ? cand[5:3] : cur_r;
    column      = (state == S_PLACE) ? cand[2:0] : cur_c;
    cur_mine    = mine_map[{cur_r, cur_c}];
    rd_cnt      = cell_rdata[6:4];
    rd_st       = cell_rdata[3:1];
    sel_unused  = cell_rdata[0];
    win_target  = 7'd64 - {3'b000, total_q};
  end

  assign total_mines    = total_q;
  assign cell_we        = cell_we_q;
  assign cell_wdata     = cell_wdata_q;
  assign game_state     = state;
  assign revealed_count = revealed_q;
  assign flags_used     = flags_q;

  // Game sequencer: setup phases, then one play action per cycle
  always_ff @(posedge clk) begin
    cell_we_q <= 1'b0;
    if (reset) begin
      state        <= S_IDLE;
      lfsr         <= DEFAULT_SEED;
      mine_map     <= '0;
      placed       <= '0;
      total_q      <= '0;
      settle_cnt   <= '0;
      cur_r        <= '0;
      cur_c        <= '0;
      revealed_q   <= '0;
      flags_q      <= '0;
      cell_wdata_q <= '0;
    end else if (start) begin
      state      <= S_CLEAR;
      lfsr       <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
      mine_map   <= '0;
      placed     <= '0;
      total_q    <= (mine_count == 4'd0) ? 4'd1 : mine_count;
      settle_cnt <= '0;
      cur_r      <= '0;
      cur_c      <= '0;
      revealed_q <= '0;
      flags_q    <= '0;
    end else begin
      case (state)
        S_CLEAR: state <= S_PLACE;
        S_PLACE: begin
          lfsr <= {lfsr[14:0], lfsr_fb};
          if (place_mine) begin
            mine_map[cand] <= 1'b1;
            placed         <= placed_next;
          end
          if (placed_next == total_q) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
          end
        end
        S_SETTLE: begin
          if (32'(settle_cnt) + 32'd1 >= SETTLE_CYCLES) state <= S_PLAY;
          else settle_cnt <= settle_cnt + 8'd1;
        end
        S_PLAY: begin
          if (btn_reveal) begin
            if (rd_st == C_HIDDEN || rd_st == C_BOMB) begin
              cell_we_q <= 1'b1;
              if (cur_mine) begin
                cell_wdata_q <= {3'b000, C_BOMB, 1'b0};
                state        <= S_LOSE;
              end else begin
                cell_wdata_q <= {rd_cnt, C_REVEALED, 1'b0};
                revealed_q   <= revealed_q + 7'd1;
                if (revealed_q + 7'd1 == win_target) state <= S_WIN;
              end
            end
          end else if (btn_flag) begin
            if (rd_st == C_HIDDEN || rd_st == C_BOMB) begin
              cell_we_q    <= 1'b1;
              cell_wdata_q <= {rd_cnt, C_FLAG, 1'b0};
              flags_q      <= flags_q + 7'd1;
            end else if (rd_st == C_FLAG) begin
              cell_we_q    <= 1'b1;
              cell_wdata_q <= {rd_cnt, (cur_mine ? C_BOMB : C_HIDDEN), 1'b0};
              flags_q      <= flags_q - 7'd1;
            end
          end else if (btn_up) begin
            if (cur_r != 3'd0) cur_r <= cur_r - 3'd1;
          end else if (btn_down) begin
            if (cur_r != 3'd7) cur_r <= cur_r + 3'd1;
          end else if (btn_left) begin
            if (cur_c != 3'd0) cur_c <= cur_c - 3'd1;
          end else if (btn_right) begin
            if (cur_c != 3'd7) cur_c <= cur_c + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minesweeper_game_ctrl.sv
// Testbench for minesweeper_game_ctrl: emulates the board (display state and
// adjacency counts) and checks the controller against a game-rule model.
module tb_minesweeper_game_ctrl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  mine_count;
  logic [15:0] seed;
  logic        btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag;
  logic [6:0]  cell_rdata;
  logic        board_reset, place_mine, cell_we;
  logic [3:0]  total_mines;
  logic [2:0]  row, column, game_state;
  logic [6:0]  cell_wdata, revealed_count, flags_used;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the game
  bit exp_mine [64];
  int mstate   [64];
  int mr, mc, mrev, mflags, mgs, mtotal;

  // Board emulation
  bit         bmine  [64];
  logic [2:0] bstate [64];

  minesweeper_game_ctrl #(.SETTLE_CYCLES(2), .DEFAULT_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .start(start), .mine_count(mine_count), .seed(seed),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_reveal(btn_reveal), .btn_flag(btn_flag), .cell_rdata(cell_rdata),
    .board_reset(board_reset), .total_mines(total_mines), .place_mine(place_mine),
    .row(row), .column(column), .cell_we(cell_we), .cell_wdata(cell_wdata),
    .game_state(game_state), .revealed_count(revealed_count), .flags_used(flags_used)
  );

  always #5 clk = ~clk;

  // Board storage: clear, mine placement and cell writes
  always @(posedge clk) begin
    if (board_reset) begin
      for (int i = 0; i < 64; i++) begin
        bmine[i]  <= 1'b0;
        bstate[i] <= 3'd0;
      end
    end else begin
      if (place_mine) bmine[{row, column}] <= 1'b1;
      if (cell_we) bstate[{row, column}] <= cell_wdata[3:1];
    end
  end

  // Board read port: neighbour count from placed mines plus display state
  always_comb begin : board_rd
    logic [3:0] n;
    int rr, cc;
    n = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = int'(row) + dr;
        cc = int'(column) + dc;
        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
          n = n + {3'b000, bmine[rr * 8 + cc]};
      end
    cell_rdata = {n[2:0], bstate[{row, column}], 1'b0};
  end

  function automatic int model_adj(input int idx);
    int r, c, n;
    r = idx / 8; c = idx % 8; n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
          n += int'(exp_mine[(r + dr) * 8 + c + dc]);
    return n % 8;
  endfunction

  function automatic int unsigned lfsr_step(input int unsigned v);
    int unsigned fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 32'hFFFF;
  endfunction

  function automatic logic [5:0] rand_btn();
    logic [5:0] b;
    b[5] = ($urandom_range(0, 7) == 0);
    for (int i = 0; i < 5; i++) b[i] = ($urandom_range(0, 2) == 0);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_btn(input logic [5:0] b);
    {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = b;
  endtask

  // One play action {reveal,flag,up,down,left,right}, predicted by the rule model
  task automatic act(input logic [5:0] b);
    int idx;
    bit exp_we;
    logic [6:0] exp_wd;
    idx = mr * 8 + mc; exp_we = 0; exp_wd = '0;
    if (mgs == 4) begin
      if (b[5]) begin
        if (mstate[idx] == 0 || mstate[idx] == 3) begin
          exp_we = 1;
          if (exp_mine[idx]) begin
            exp_wd = {3'd0, 3'd3, 1'b0}; mstate[idx] = 3; mgs = 6;
          end else begin
            exp_wd = {3'(model_adj(idx)), 3'd1, 1'b0}; mstate[idx] = 1; mrev++;
            if (mrev == 64 - mtotal) mgs = 5;
          end
        end
      end else if (b[4]) begin
        if (mstate[idx] == 0 || mstate[idx] == 3) begin
          exp_we = 1; exp_wd = {3'(model_adj(idx)), 3'd2, 1'b0}; mstate[idx] = 2; mflags++;
        end else if (mstate[idx] == 2) begin
          mstate[idx] = exp_mine[idx] ? 3 : 0;
          exp_we = 1; exp_wd = {3'(model_adj(idx)), 3'(mstate[idx]), 1'b0}; mflags--;
        end
      end else if (b[3]) mr = (mr > 0) ? mr - 1 : 0;
      else if (b[2]) mr = (mr < 7) ? mr + 1 : 7;
      else if (b[1]) mc = (mc > 0) ? mc - 1 : 0;
      else if (b[0]) mc = (mc < 7) ? mc + 1 : 7;
    end
    drive_btn(b);
    tick();
    drive_btn('0);
    n_cmp++;
    if (cell_we !== exp_we) begin
      n_bad++; $display("FAIL act_we btn=%b: got %b want %b", b, cell_we, exp_we);
    end
    if (exp_we) begin
      n_cmp++;
      if (cell_wdata !== exp_wd) begin
        n_bad++; $display("FAIL act_wdata (%0d,%0d): got %h want %h", mr, mc, cell_wdata, exp_wd);
      end
    end
    n_cmp++;
    if ({row, column} !== {3'(mr), 3'(mc)}) begin
      n_bad++; $display("FAIL act_cursor: got (%0d,%0d) want (%0d,%0d)", row, column, mr, mc);
    end
    n_cmp++;
    if (game_state !== 3'(mgs) || revealed_count !== 7'(mrev) || flags_used !== 7'(mflags)) begin
      n_bad++;
      $display("FAIL act_status: got st=%0d rev=%0d fl=%0d want st=%0d rev=%0d fl=%0d",
               game_state, revealed_count, flags_used, mgs, mrev, mflags);
    end
    tick();
    n_cmp++;
    if (cell_we !== 1'b0) begin
      n_bad++; $display("FAIL idle_we: got %b want 0", cell_we);
    end
  endtask

  task automatic goto_cell(input int r, input int c);
    while (mgs == 4 && mr > r) act(6'b001000);
    while (mgs == 4 && mr < r) act(6'b000100);
    while (mgs == 4 && mc > c) act(6'b000010);
    while (mgs == 4 && mc < c) act(6'b000001);
  endtask

  // Start a game and check clear, every placement cycle, settle, and PLAY entry
  task automatic new_game(input logic [15:0] sv, input logic [3:0] cnt, input bit jitter);
    int unsigned l;
    int placed, k, cand;
    bit exp_pl;
    start = 1; mine_count = cnt; seed = sv;
    tick();
    start = 0;
    mtotal = (cnt == 0) ? 1 : int'(cnt);
    for (int i = 0; i < 64; i++) begin exp_mine[i] = 0; mstate[i] = 0; end
    mr = 0; mc = 0; mrev = 0; mflags = 0;
    n_cmp++;
    if (game_state !== 3'd1 || board_reset !== 1'b1 || total_mines !== 4'(mtotal) ||
        revealed_count !== 7'd0 || flags_used !== 7'd0) begin
      n_bad++;
      $display("FAIL clear: got st=%0d br=%b tm=%0d rev=%0d fl=%0d want st=1 br=1 tm=%0d rev=0 fl=0",
               game_state, board_reset, total_mines, revealed_count, flags_used, mtotal);
    end
    l = (sv == 16'h0) ? 32'hACE1 : 32'(sv);
    placed = 0; k = 0;
    if (jitter) drive_btn(rand_btn());
    tick();
    while (placed < mtotal) begin
      if (k > 4000) begin
        n_bad++; $display("FAIL place_budget: got %0d placed want %0d", placed, mtotal);
        break;
      end
      cand = int'(l & 63);
      exp_pl = !exp_mine[cand];
      n_cmp++;
      if (game_state !== 3'd2 || place_mine !== exp_pl || cell_we !== 1'b0) begin
        n_bad++;
        $display("FAIL place cyc%0d: got st=%0d pm=%b we=%b want st=2 pm=%b we=0",
                 k, game_state, place_mine, cell_we, exp_pl);
      end
      if (exp_pl) begin
        n_cmp++;
        if ({row, column} !== 6'(cand)) begin
          n_bad++; $display("FAIL place_pos cyc%0d: got %0d want %0d", k, {row, column}, cand);
        end
        exp_mine[cand] = 1; placed++;
      end
      l = lfsr_step(l); k++;
      if (jitter) drive_btn(rand_btn());
      tick();
    end
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if (game_state !== 3'd3 || place_mine !== 1'b0) begin
        n_bad++; $display("FAIL settle%0d: got st=%0d pm=%b want st=3 pm=0", s, game_state, place_mine);
      end
      if (jitter) drive_btn(rand_btn());
      tick();
    end
    drive_btn('0);
    mgs = 4;
    n_cmp++;
    if (game_state !== 3'd4 || row !== 3'd0 || column !== 3'd0 || cell_we !== 1'b0) begin
      n_bad++; $display("FAIL play_entry: got st=%0d (%0d,%0d) we=%b want st=4 (0,0) we=0",
                        game_state, row, column, cell_we);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (game_state !== 3'd0 || row !== 3'd0 || column !== 3'd0 || place_mine !== 1'b0 ||
        cell_we !== 1'b0 || board_reset !== 1'b0 || total_mines !== 4'd0 ||
        revealed_count !== 7'd0 || flags_used !== 7'd0) begin
      n_bad++;
      $display("FAIL reset: got st=%0d r=%0d c=%0d pm=%b we=%b br=%b tm=%0d rev=%0d fl=%0d want all 0",
               game_state, row, column, place_mine, cell_we, board_reset, total_mines,
               revealed_count, flags_used);
    end
    mgs = 0;
  endtask

  task automatic test_placement();
    new_game(16'h0001, 4'd5, 1'b0);
    new_game(16'(16'h1234 + $urandom_range(0, 999)), 4'd0, 1'b1);
    new_game(16'h0000, 4'd15, 1'b1);
  endtask

  task automatic test_cursor();
    new_game(16'(1 + $urandom_range(0, 60000)), 4'd3, 1'b0);
    act(6'b001000);
    act(6'b000010);
    n_cmp++;
    if (row !== 3'd0 || column !== 3'd0) begin
      n_bad++; $display("FAIL cursor_sat_low: got (%0d,%0d) want (0,0)", row, column);
    end
    for (int i = 0; i < 8; i++) act(6'b000001);
    n_cmp++;
    if (column !== 3'd7) begin
      n_bad++; $display("FAIL cursor_sat_high: got %0d want 7", column);
    end
    for (int i = 0; i < 9; i++) act(6'b000100);
    for (int i = 0; i < 20; i++) act(6'($urandom_range(1, 15)));
  endtask

  task automatic test_flag();
    int m;
    new_game(16'(1 + $urandom_range(0, 60000)), 4'd8, 1'b0);
    m = 0;
    while (!exp_mine[m]) m++;
    goto_cell(m / 8, m % 8);
    act(6'b010000);
    n_cmp++;
    if (flags_used !== 7'd1) begin
      n_bad++; $display("FAIL flag_count: got %0d want 1", flags_used);
    end
    act(6'b010000);
    n_cmp++;
    if (flags_used !== 7'd0 || cell_wdata[3:1] !== 3'd3) begin
      n_bad++; $display("FAIL unflag_mine: got fl=%0d st=%0d want fl=0 st=3", flags_used, cell_wdata[3:1]);
    end
    act(6'b010000);
    act(6'b100000);
    n_cmp++;
    if (game_state !== 3'd4) begin
      n_bad++; $display("FAIL reveal_flagged: got st=%0d want 4", game_state);
    end
    act(6'b010000);
    act(6'b110000);
  endtask

  task automatic test_lose();
    int m;
    new_game(16'(1 + $urandom_range(0, 60000)), 4'd6, 1'b0);
    m = 63;
    while (!exp_mine[m]) m--;
    goto_cell(m / 8, m % 8);
    act(6'b100000);
    n_cmp++;
    if (game_state !== 3'd6) begin
      n_bad++; $display("FAIL lose: got st=%0d want 6", game_state);
    end
    for (int i = 0; i < 10; i++) act(rand_btn() | 6'b110000);
  endtask

  task automatic test_win();
    int c;
    new_game(16'(1 + $urandom_range(0, 60000)), 4'd1, 1'b0);
    for (int r = 0; r < 8 && mgs == 4; r++)
      for (int i = 0; i < 8 && mgs == 4; i++) begin
        c = (r % 2 == 0) ? i : 7 - i;
        goto_cell(r, c);
        if (!exp_mine[r * 8 + c]) act(6'b100000);
      end
    n_cmp++;
    if (game_state !== 3'd5 || revealed_count !== 7'd63) begin
      n_bad++; $display("FAIL win: got st=%0d rev=%0d want st=5 rev=63", game_state, revealed_count);
    end
    for (int i = 0; i < 5; i++) act(rand_btn() | 6'b100000);
    new_game(16'(1 + $urandom_range(0, 60000)), 4'(1 + $urandom_range(0, 14)), 1'b0);
  endtask

  task automatic test_random_play();
    for (int g = 0; g < 6; g++) begin
      new_game(16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)), 1'b1);
      for (int i = 0; i < 120; i++) act(rand_btn());
    end
  endtask

  task automatic test_reset_mid_place();
    start = 1; mine_count = 4'd15; seed = 16'(1 + $urandom_range(0, 60000));
    tick();
    start = 0;
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    test_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (place_mine !== 1'b0 || game_state !== 3'd0) begin
        n_bad++; $display("FAIL post_reset%0d: got pm=%b st=%0d want pm=0 st=0", i, place_mine, game_state);
      end
    end
  endtask

  initial begin
    reset = 1; start = 0; mine_count = '0; seed = '0;
    drive_btn('0);
    tick();
    tick();
    reset = 0;
    test_reset();
    test_placement();
    test_cursor();
    test_flag();
    test_lose();
    test_win();
    test_random_play();
    test_reset_mid_place();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
